countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Loadable down-counter with programmable prescaler, terminal-count pulse and optional auto-reload.
- It is the counterpart to the up-counting `counter` block: software or an FSM loads an interval, and the block counts it down to zero and signals expiry.
- Sits beside `counter` and `dff` in the timing/utility layer, feeding interrupt and timeout logic.

Parameters:
- WIDTH, 4, width of count, load_val and internal reload register.
- PRESCALE_W, 4, width of prescale input and internal prescale counter.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  reset, synchronous and active-low; same `rst` stem as the codebase, with `_n` marking polarity.
- load  input  1  load load_val into count and the reload register.
- load_val  input  WIDTH  interval to load.
- prescale  input  PRESCALE_W  one decrement tick per (prescale+1) enabled cycles.
- enable  input  1  run/pause; low freezes count and prescale counter.
- auto_reload  input  1  1 = reload on expiry and keep running; 0 = stop at zero.
- count  output  WIDTH  current count (registered).
- tc  output  1  terminal-count pulse (registered).
- busy  output  1  high while in RUN.
- expired  output  1  sticky; set on one-shot expiry, cleared by load or reset.

Behaviour:
- **Reset.** rst_n sampled low at a rising clk edge has highest priority, above load. Afterwards count=0, tc=0, busy=0, expired=0, pre_cnt=0, reload_reg=0, state=IDLE.
- **States.**
  - IDLE: busy=0; count holds.
  - RUN: busy=1.
  - EXPIRED: busy=0, expired=1, count=0.
- **Load (any state), priority over tick.**
  - Next cycle: count=load_val, reload_reg=load_val, pre_cnt=0, expired=0, tc=0.
  - Next state is RUN if load_val!=0, else IDLE (no tc for a zero load).
  - Latency is 1 cycle from load to the new count.
- **Prescaler.**
  - Active only in RUN with enable=1 and load=0.
  - If pre_cnt>=prescale: pre_cnt<=0 and a tick fires; else pre_cnt<=pre_cnt+1.
  - The >= compare keeps a mid-run reduction of prescale from wrapping.
  - prescale=0 gives a tick every enabled cycle.
- **Tick in RUN.**
  - count>1: count<=count-1; tc<=0.
  - count==1 and auto_reload=1: count<=reload_reg, tc<=1, stay in RUN.
  - count==1 and auto_reload=0: count<=0, tc<=1, expired<=1, go to EXPIRED. busy falls in the same cycle tc rises.
- **tc.** High for exactly one cycle per expiry, in the cycle count first shows the new value. Back-to-back ticks are only possible with reload_reg=1 and prescale=0, in which case tc stays high continuously.
- **Pause.** enable=0 in RUN holds count, pre_cnt and state; tc<=0.
- **EXPIRED / IDLE.** enable and auto_reload are ignored; the block leaves these states only via load (or reset).
- **auto_reload timing.** auto_reload is sampled on the expiry tick itself, so changing it mid-run takes effect at the next expiry.
- **Arithmetic.** Unsigned throughout; count never decrements below 0; no wrap from 0 to all-ones.

Decomposition:
- Shared package `timer_pkg`:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_EXPIRED=2'd2;
  - default WIDTH/PRESCALE_W constants.
- One sub-module, `tick_prescaler`:
  - ports: clk, rst_n, clear, run, prescale, tick;
  - contains pre_cnt and the >= compare.
- The top level holds the FSM, count, reload_reg and flags.

Test Plan:
1. **Reset.** Hold rst_n=0 for 2 cycles while load=1, load_val=7 → count=0, tc=0, busy=0, expired=0 (reset beats load).
2. **One-shot.** load_val=5, prescale=0, enable=1, auto_reload=0 → count 5,4,3,2,1,0 on consecutive cycles. tc=1 only in the count==0 cycle; busy drops in that cycle; expired=1 and holds; further enable has no effect.
3. **Prescale and pause.** load_val=3, prescale=2 → one decrement per 3 cycles. Drop enable for 4 cycles mid-interval → count and prescale phase frozen; on resume, the remaining prescale cycles complete before the next decrement.
4. **Auto-reload.** load_val=3, prescale=0, auto_reload=1 → count 3,2,1,3,2,1,3 with tc on every cycle showing the reloaded 3 (every 3 cycles); busy stays 1.
5. **Load edge cases.**
   - load_val=0 → IDLE, busy=0, tc never asserts.
   - During RUN at count=2, load load_val=9 with enable=1 in the same cycle → next count=9 (no decrement), pre_cnt=0.
   - load from EXPIRED → expired clears and RUN resumes.
6. **Degenerate reload.** load_val=1, prescale=0, auto_reload=1 → count stays 1 and tc is continuously 1 from the first tick. Deassert enable → tc=0 the next cycle.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and default widths for countdown_timer
package timer_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;
    localparam int DEF_WIDTH      = 4;
    localparam int DEF_PRESCALE_W = 4;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: emits one tick per (prescale+1) run cycles; >= compare tolerates prescale shrinking mid-count
module tick_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);
    logic [PRESCALE_W-1:0] pre_cnt;

    assign tick = run && (pre_cnt >= prescale);

    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            pre_cnt <= '0;
        else if (run)
            pre_cnt <= tick ? '0 : pre_cnt + PRESCALE_W'(1);
    end
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable prescaled down-counter with terminal-count pulse and optional auto-reload
module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  enable,
    input  logic                  auto_reload,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  busy,
    output logic                  expired
);
    state_t           state, state_n;
    logic [WIDTH-1:0] reload_reg, reload_n, count_n;
    logic             tc_n, tick;

    tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_pre (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (load),
        .run      (state == ST_RUN && enable && !load),
        .prescale (prescale),
        .tick     (tick)
    );

    assign busy    = state == ST_RUN;
    assign expired = state == ST_EXPIRED;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            count      <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            reload_reg <= reload_n;
            tc         <= tc_n;
        end
    end

    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload_reg;
        tc_n     = 1'b0;
        if (load) begin
            count_n  = load_val;
            reload_n = load_val;
            state_n  = (load_val != '0) ? ST_RUN : ST_IDLE;
        end else if (tick) begin
            if (count > WIDTH'(1)) begin
                count_n = count - WIDTH'(1);
            end else begin
                tc_n    = 1'b1;
                count_n = auto_reload ? reload_reg : '0;
                state_n = auto_reload ? ST_RUN : ST_EXPIRED;
            end
        end
    end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: vector table, hand-written prescale/pause sequence, and randomized run against a behavioural model
module tb_countdown_timer;
    logic       clk = 1'b0;
    logic       rst_n, load, enable, auto_reload;
    logic [3:0] load_val, prescale;
    logic [3:0] count;
    logic       tc, busy, expired;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic       rst_n, load;
        logic [3:0] lv, ps;
        logic       en, ar;
        logic [3:0] cnt;
        logic       tc, busy, exp;
    } vec_t;

    vec_t vecs[$];

    countdown_timer #(.WIDTH(4), .PRESCALE_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .load_val    (load_val),
        .prescale    (prescale),
        .enable      (enable),
        .auto_reload (auto_reload),
        .count       (count),
        .tc          (tc),
        .busy        (busy),
        .expired     (expired)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit r, bit l, int lv, int ps, bit en, bit ar,
                                int c, bit t, bit b, bit e);
        vec_t v;
        v.rst_n = r;  v.load = l;  v.lv = 4'(lv); v.ps = 4'(ps);
        v.en = en;    v.ar = ar;   v.cnt = 4'(c); v.tc = t;
        v.busy = b;   v.exp = e;
        return v;
    endfunction

    task automatic check(string name, logic [6:0] got, logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got count=%0d tc=%0b busy=%0b expired=%0b, want count=%0d tc=%0b busy=%0b expired=%0b",
                     name, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic run_vec(vec_t v, string name);
        rst_n = v.rst_n; load = v.load; load_val = v.lv; prescale = v.ps;
        enable = v.en; auto_reload = v.ar;
        @(posedge clk);
        #1;
        check(name, {count, tc, busy, expired}, {v.cnt, v.tc, v.busy, v.exp});
    endtask

    // behavioural model: plain integers describing the timer's observable meaning
    int  m_cnt, m_rld, m_phase, m_mode;
    bit  m_tc;

    task automatic model_step(bit r, bit l, int lv, int ps, bit en, bit ar);
        if (!r) begin
            m_cnt = 0; m_rld = 0; m_phase = 0; m_mode = 0; m_tc = 0;
        end else if (l) begin
            m_cnt = lv; m_rld = lv; m_phase = 0; m_tc = 0;
            m_mode = (lv != 0) ? 1 : 0;
        end else begin
            m_tc = 0;
            if (m_mode == 1 && en) begin
                if (m_phase >= ps) begin
                    m_phase = 0;
                    if (m_cnt > 1) m_cnt = m_cnt - 1;
                    else begin
                        m_tc = 1;
                        if (ar) m_cnt = m_rld;
                        else begin m_cnt = 0; m_mode = 2; end
                    end
                end else m_phase = m_phase + 1;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; load_val = '0; prescale = '0;
        enable = 1'b0; auto_reload = 1'b0;
        // reset beats load
        vecs.push_back(mk(0,1,7,0,1,0, 0,0,0,0));
        vecs.push_back(mk(0,1,7,0,1,0, 0,0,0,0));
        // one-shot countdown from 5
        vecs.push_back(mk(1,1,5,0,1,0, 5,0,1,0));
        vecs.push_back(mk(1,0,5,0,1,0, 4,0,1,0));
        vecs.push_back(mk(1,0,5,0,1,0, 3,0,1,0));
        vecs.push_back(mk(1,0,5,0,1,0, 2,0,1,0));
        vecs.push_back(mk(1,0,5,0,1,0, 1,0,1,0));
        vecs.push_back(mk(1,0,5,0,1,0, 0,1,0,1));
        vecs.push_back(mk(1,0,5,0,1,1, 0,0,0,1));
        vecs.push_back(mk(1,0,5,0,1,1, 0,0,0,1));
        // load from EXPIRED, then auto-reload
        vecs.push_back(mk(1,1,3,0,1,1, 3,0,1,0));
        vecs.push_back(mk(1,0,3,0,1,1, 2,0,1,0));
        vecs.push_back(mk(1,0,3,0,1,1, 1,0,1,0));
        vecs.push_back(mk(1,0,3,0,1,1, 3,1,1,0));
        vecs.push_back(mk(1,0,3,0,1,1, 2,0,1,0));
        vecs.push_back(mk(1,0,3,0,1,1, 1,0,1,0));
        vecs.push_back(mk(1,0,3,0,1,1, 3,1,1,0));
        vecs.push_back(mk(1,0,3,0,1,1, 2,0,1,0));
        // load during RUN with enable: no decrement that cycle
        vecs.push_back(mk(1,1,9,0,1,1, 9,0,1,0));
        vecs.push_back(mk(1,0,9,0,1,1, 8,0,1,0));
        // zero load goes IDLE with no tc
        vecs.push_back(mk(1,1,0,0,1,1, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0,1,1, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0,1,0, 0,0,0,0));
        // degenerate reload of 1: continuous tc until paused
        vecs.push_back(mk(1,1,1,0,1,1, 1,0,1,0));
        vecs.push_back(mk(1,0,1,0,1,1, 1,1,1,0));
        vecs.push_back(mk(1,0,1,0,1,1, 1,1,1,0));
        vecs.push_back(mk(1,0,1,0,1,1, 1,1,1,0));
        vecs.push_back(mk(1,0,1,0,0,1, 1,0,1,0));
        vecs.push_back(mk(1,0,1,0,0,1, 1,0,1,0));

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // prescale=2 with a 4-cycle pause mid-interval
        run_vec(mk(1,1,3,2,1,0, 3,0,1,0), "ps_load");
        run_vec(mk(1,0,3,2,1,0, 3,0,1,0), "ps_ph1");
        run_vec(mk(1,0,3,2,1,0, 3,0,1,0), "ps_ph2");
        run_vec(mk(1,0,3,2,1,0, 2,0,1,0), "ps_tick1");
        run_vec(mk(1,0,3,2,1,0, 2,0,1,0), "ps_ph1b");
        for (int i = 0; i < 4; i++)
            run_vec(mk(1,0,3,2,0,0, 2,0,1,0), $sformatf("ps_pause%0d", i));
        run_vec(mk(1,0,3,2,1,0, 2,0,1,0), "ps_resume");
        run_vec(mk(1,0,3,2,1,0, 1,0,1,0), "ps_tick2");
        run_vec(mk(1,0,3,2,1,0, 1,0,1,0), "ps_ph1c");
        run_vec(mk(1,0,3,2,1,0, 1,0,1,0), "ps_ph2c");
        run_vec(mk(1,0,3,2,1,0, 0,1,0,1), "ps_expire");

        // randomized run against the model, starting from a reset
        model_step(0, 0, 0, 0, 0, 0);
        run_vec(mk(0,0,0,0,0,0, 0,0,0,0), "rnd_reset");
        for (int i = 0; i < 600; i++) begin
            bit r, l, en, ar;
            int lv, ps;
            r  = ($urandom_range(0, 99) != 0);
            l  = ($urandom_range(0, 11) == 0);
            lv = $urandom_range(0, 6);
            ps = $urandom_range(0, 3);
            en = ($urandom_range(0, 4) != 0);
            ar = $urandom_range(0, 1);
            model_step(r, l, lv, ps, en, ar);
            run_vec(mk(r, l, lv, ps, en, ar, m_cnt, m_tc, m_mode == 1, m_mode == 2),
                    $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
